// File: rtl/mem_responder.sv
// Word-organised RAM behind a byte-addressed request port, with configurable
// wait states, fault flagging for misaligned/out-of-range accesses and a busy stall.
module mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic                  i_mem_write,
   input  logic [WORD_WIDTH-1:0] i_mem_wdata,
   output logic [WORD_WIDTH-1:0] o_mem_data,
   output logic                  o_ready,
   output logic                  o_fault,
   output logic                  o_busy
);

   localparam int unsigned OFFS = $clog2(WORD_WIDTH / 8);
   localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic S_IDLE = 1'b0;
   localparam logic S_WAIT = 1'b1;

   logic                  state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  fault_q, fault_d;

   logic [WORD_WIDTH-1:0] mem_q [DEPTH];

   logic                  accept;
   logic                  complete;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_wr;
   logic [WORD_WIDTH-1:0] acc_wdata;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [IDXW-1:0]       mem_idx;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  bad;
   logic                  mem_we;

   assign accept = (state_q == S_IDLE) && i_req;

   // With no wait states the access completes on the accept edge, so the
   // live inputs are used; otherwise the latched copy drives the completion.
   assign complete  = (WAIT_STATES == 0) ? accept
                                         : ((state_q == S_WAIT) && (cnt_q == 4'd1));
   assign acc_addr  = (WAIT_STATES == 0) ? i_mem_addr  : addr_q;
   assign acc_wr    = (WAIT_STATES == 0) ? i_mem_write : wr_q;
   assign acc_wdata = (WAIT_STATES == 0) ? i_mem_wdata : wdata_q;

   assign word_idx     = acc_addr >> OFFS;
   assign mem_idx      = word_idx[IDXW-1:0];
   assign misaligned   = |(acc_addr & ADDR_WIDTH'((1 << OFFS) - 1));
   assign out_of_range = {1'b0, word_idx} >= (ADDR_WIDTH + 1)'(DEPTH);
   assign bad          = misaligned || out_of_range;
   assign mem_we       = complete && !bad && acc_wr && i_rst_n;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      fault_d = 1'b0;

      if (accept) begin
         addr_d  = i_mem_addr;
         wr_d    = i_mem_write;
         wdata_d = i_mem_wdata;
         if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
         end
      end else if (state_q == S_WAIT) begin
         if (cnt_q != 4'd1) begin
            cnt_d = cnt_q - 4'd1;
         end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      end

      if (complete) begin
         ready_d = 1'b1;
         if (bad) begin
            fault_d = 1'b1;
            rdata_d = '0;
         end else if (!acc_wr) begin
            rdata_d = mem_q[mem_idx];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
      end
   end

   // Memory contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[mem_idx] <= acc_wdata;
      end
   end

   assign o_mem_data = rdata_q;
   assign o_ready    = ready_q;
   assign o_fault    = fault_q;
   assign o_busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 0, 2 and 3 wait states
// share one clock; expected values are hand-computed constants.
module tb_mem_responder;

   localparam int unsigned AW = 16;
   localparam int unsigned WW = 32;

   logic          clk;
   logic          rst_n [3];
   logic          req   [3];
   logic [AW-1:0] addr  [3];
   logic          wr    [3];
   logic [WW-1:0] wdata [3];
   logic [WW-1:0] rdata [3];
   logic          ready [3];
   logic          fault [3];
   logic          busy  [3];

   int unsigned wcfg [3];
   int nvec;
   int nerr;

   mem_responder #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(256), .WAIT_STATES(0)) u_w0 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_req(req[0]), .i_mem_addr(addr[0]),
      .i_mem_write(wr[0]), .i_mem_wdata(wdata[0]), .o_mem_data(rdata[0]),
      .o_ready(ready[0]), .o_fault(fault[0]), .o_busy(busy[0]));

   mem_responder #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(256), .WAIT_STATES(2)) u_w2 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_req(req[1]), .i_mem_addr(addr[1]),
      .i_mem_write(wr[1]), .i_mem_wdata(wdata[1]), .o_mem_data(rdata[1]),
      .o_ready(ready[1]), .o_fault(fault[1]), .o_busy(busy[1]));

   mem_responder #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(256), .WAIT_STATES(3)) u_w3 (
      .i_clk(clk), .i_rst_n(rst_n[2]), .i_req(req[2]), .i_mem_addr(addr[2]),
      .i_mem_write(wr[2]), .i_mem_wdata(wdata[2]), .o_mem_data(rdata[2]),
      .o_ready(ready[2]), .o_fault(fault[2]), .o_busy(busy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request, then wait (bounded) for the response; checks latency and pulse width.
   task automatic access(input int d, input logic w, input logic [AW-1:0] a,
                         input logic [WW-1:0] wd, output logic [WW-1:0] data,
                         output logic flt);
      int unsigned cyc;
      @(negedge clk);
      req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
      @(posedge clk); #1;
      req[d] = 1'b0;
      cyc = 0;
      while (!ready[d] && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("resp_seen", {31'b0, ready[d]}, 32'd1);
      chk("resp_latency", cyc, wcfg[d]);
      data = rdata[d];
      flt  = fault[d];
      @(posedge clk); #1;
      chk("resp_one_cycle", {31'b0, ready[d]}, 32'd0);
   endtask

   logic [WW-1:0] d_o;
   logic          f_o;

   initial begin
      nvec = 0;
      nerr = 0;
      wcfg[0] = 0; wcfg[1] = 2; wcfg[2] = 3;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; req[i] = 1'b0; addr[i] = '0; wr[i] = 1'b0; wdata[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_outputs", {rdata[i][30:0] | {30'b0, ready[i]}, fault[i] | busy[i]}, 32'd0);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

      // Back-to-back write then read with no wait states
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 32'hDEADBEEF;
      @(posedge clk); #1;
      chk("b2b_wr_ready", {31'b0, ready[0]}, 32'd1);
      chk("b2b_wr_busy",  {31'b0, busy[0]},  32'd0);
      wr[0] = 1'b0;
      @(posedge clk); #1;
      chk("b2b_rd_ready", {31'b0, ready[0]}, 32'd1);
      chk("b2b_rd_data",  rdata[0], 32'hDEADBEEF);
      chk("b2b_rd_busy",  {31'b0, busy[0]},  32'd0);
      req[0] = 1'b0;
      @(posedge clk); #1;
      chk("b2b_idle_ready", {31'b0, ready[0]}, 32'd0);

      // Misaligned write is rejected and leaves memory alone
      access(0, 1'b1, 16'h0012, 32'h12345678, d_o, f_o);
      chk("misal_fault", {31'b0, f_o}, 32'd1);
      chk("misal_data",  d_o, 32'h0);
      access(0, 1'b0, 16'h0010, '0, d_o, f_o);
      chk("misal_after_data",  d_o, 32'hDEADBEEF);
      chk("misal_after_fault", {31'b0, f_o}, 32'd0);

      // Out of range, then the last valid word
      access(0, 1'b0, 16'h0400, '0, d_o, f_o);
      chk("oor_fault", {31'b0, f_o}, 32'd1);
      chk("oor_data",  d_o, 32'h0);
      access(0, 1'b0, 16'h03FC, '0, d_o, f_o);
      chk("last_word_fault", {31'b0, f_o}, 32'd0);

      // Response data held across a write response
      access(0, 1'b0, 16'h0010, '0, d_o, f_o);
      chk("hold_rd_data", d_o, 32'hDEADBEEF);
      access(0, 1'b1, 16'h0014, 32'h0, d_o, f_o);
      chk("hold_wr_data",  d_o, 32'hDEADBEEF);
      chk("hold_wr_fault", {31'b0, f_o}, 32'd0);

      // Two wait states: busy window, response slot, ignored request while busy
      access(1, 1'b1, 16'h0010, 32'hDEADBEEF, d_o, f_o);
      @(negedge clk);
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0010;
      @(posedge clk); #1;
      chk("w2_k_busy",  {31'b0, busy[1]},  32'd1);
      chk("w2_k_ready", {31'b0, ready[1]}, 32'd0);
      wr[1] = 1'b1; wdata[1] = 32'h11111111;
      @(posedge clk); #1;
      chk("w2_k1_busy",  {31'b0, busy[1]},  32'd1);
      chk("w2_k1_ready", {31'b0, ready[1]}, 32'd0);
      @(posedge clk); #1;
      req[1] = 1'b0;
      chk("w2_k2_busy",  {31'b0, busy[1]},  32'd0);
      chk("w2_k2_ready", {31'b0, ready[1]}, 32'd1);
      chk("w2_k2_data",  rdata[1], 32'hDEADBEEF);
      @(posedge clk); #1;
      chk("w2_k3_ready", {31'b0, ready[1]}, 32'd0);
      chk("w2_k3_busy",  {31'b0, busy[1]},  32'd0);
      access(1, 1'b0, 16'h0010, '0, d_o, f_o);
      chk("w2_ignored_wr", d_o, 32'hDEADBEEF);

      // Three wait states: reset mid-write drops the access
      access(2, 1'b1, 16'h0020, 32'h0, d_o, f_o);
      access(2, 1'b1, 16'h0024, 32'h55AA55AA, d_o, f_o);
      access(2, 1'b0, 16'h0024, '0, d_o, f_o);
      chk("w3_pre_data", d_o, 32'h55AA55AA);
      @(negedge clk);
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 16'h0020; wdata[2] = 32'hCAFEF00D;
      @(posedge clk); #1;
      req[2] = 1'b0;
      chk("rst_mid_busy", {31'b0, busy[2]}, 32'd1);
      @(posedge clk); #2;
      rst_n[2] = 1'b0;
      #1;
      chk("rst_mid_data",  rdata[2], 32'h0);
      chk("rst_mid_flags", {29'b0, ready[2], fault[2], busy[2]}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rst_hold_ready", {31'b0, ready[2]}, 32'd0);
      end
      @(negedge clk);
      rst_n[2] = 1'b1;
      @(posedge clk); #1;
      chk("rst_after_ready", {31'b0, ready[2]}, 32'd0);
      access(2, 1'b0, 16'h0020, '0, d_o, f_o);
      chk("rst_dropped_wr", d_o, 32'h0);
      chk("rst_dropped_fault", {31'b0, f_o}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
